// File: rtl/food_pkg.sv
// Shared types and constants for the food pellet controller.
package food_pkg;

  typedef enum logic [1:0] {IDLE, INIT, PLAY, DONE} food_state_t;

  localparam int TILE_SHIFT    = 4;
  localparam int PELLET_POINTS = 10;

  typedef logic [4:0] tile_idx_t;

endpackage

// File: rtl/food_pellet_ctrl_if.sv
// Bus bundle between food_pellet_ctrl and its neighbours.
// The score signal exists only when FOOD_SCORE_EN is defined.
interface food_pellet_ctrl_if
  import food_pkg::*;
#(
  parameter int CNT_W = 10
);
  logic             level_start;
  logic             pac_valid;
  tile_idx_t        pac_tile_x;
  tile_idx_t        pac_tile_y;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic [3:0]       food_rom_addr;
  logic [7:0]       food_rom_data;
  logic             food_on;
  logic             eat_pulse;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             level_clear;
`ifdef FOOD_SCORE_EN
  logic [CNT_W+3:0] score;

  modport slave (
    input  level_start, pac_valid, pac_tile_x, pac_tile_y, DrawX, DrawY, food_rom_data,
    output food_rom_addr, food_on, eat_pulse, remaining, busy, level_clear, score
  );
  modport master (
    output level_start, pac_valid, pac_tile_x, pac_tile_y, DrawX, DrawY, food_rom_data,
    input  food_rom_addr, food_on, eat_pulse, remaining, busy, level_clear, score
  );
`else
  modport slave (
    input  level_start, pac_valid, pac_tile_x, pac_tile_y, DrawX, DrawY, food_rom_data,
    output food_rom_addr, food_on, eat_pulse, remaining, busy, level_clear
  );
  modport master (
    output level_start, pac_valid, pac_tile_x, pac_tile_y, DrawX, DrawY, food_rom_data,
    input  food_rom_addr, food_on, eat_pulse, remaining, busy, level_clear
  );
`endif
endinterface

// File: rtl/food_bitmap.sv
// Pellet presence storage with row fill, single-bit clear, two combinational
// read ports (Pac-Man tile and pixel tile) and the remaining-pellet counter.
module food_bitmap
  import food_pkg::*;
#(
  parameter int GRID_W = 28,
  parameter int GRID_H = 30,
  parameter int CNT_W  = 10
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             fill_en,
  input  tile_idx_t        fill_row,
  input  logic             load_en,
  input  logic             clr_en,
  input  tile_idx_t        pac_x,
  input  tile_idx_t        pac_y,
  output logic             pac_bit,
  input  tile_idx_t        pix_x,
  input  tile_idx_t        pix_y,
  output logic             pix_bit,
  output logic [CNT_W-1:0] remaining
);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(GRID_W * GRID_H);

  logic [GRID_W-1:0] rows_q [GRID_H];
  logic [GRID_W-1:0] rows_d [GRID_H];
  logic [CNT_W-1:0]  remaining_q, remaining_d;

  function automatic logic in_range(input tile_idx_t x, input tile_idx_t y);
    return ({1'b0, x} < 6'(GRID_W)) && ({1'b0, y} < 6'(GRID_H));
  endfunction

  always_comb begin
    pac_bit = 1'b0;
    if (in_range(pac_x, pac_y)) pac_bit = rows_q[pac_y][pac_x];
  end

  always_comb begin
    pix_bit = 1'b0;
    if (in_range(pix_x, pix_y)) pix_bit = rows_q[pix_y][pix_x];
  end

  // The clear port shares the Pac-Man address; the caller only asserts it on a set bit.
  always_comb begin
    rows_d      = rows_q;
    remaining_d = remaining_q;
    if (fill_en) rows_d[fill_row] = '1;
    if (clr_en) begin
      rows_d[pac_y][pac_x] = 1'b0;
      remaining_d          = remaining_q - CNT_W'(1);
    end
    if (load_en) remaining_d = FULL_CNT;
  end

  genvar gi;
  generate
    for (gi = 0; gi < GRID_H; gi++) begin : g_row
      always_ff @(posedge Clk) begin
        if (!Reset_n) rows_q[gi] <= '0;
        else          rows_q[gi] <= rows_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Reset_n) remaining_q <= '0;
    else          remaining_q <= remaining_d;
  end

  assign remaining = remaining_q;

endmodule

// File: rtl/food_pellet_ctrl.sv
// Level FSM, eat logic and 2-stage food pixel pipeline over food_bitmap.
// Define FOOD_SCORE_EN to add the saturating score output.
module food_pellet_ctrl
  import food_pkg::*;
#(
  parameter int GRID_W   = 28,
  parameter int GRID_H   = 30,
  parameter int ORIGIN_X = 96,
  parameter int ORIGIN_Y = 0,
  parameter int CNT_W    = 10
) (
  input logic Clk,
  input logic Reset_n,
  food_pellet_ctrl_if.slave bus
);
  localparam tile_idx_t   LAST_ROW = tile_idx_t'(GRID_H - 1);
  localparam logic [31:0] X_LO     = 32'(ORIGIN_X);
  localparam logic [31:0] X_HI     = 32'(ORIGIN_X + (GRID_W << TILE_SHIFT));
  localparam logic [31:0] Y_LO     = 32'(ORIGIN_Y);
  localparam logic [31:0] Y_HI     = 32'(ORIGIN_Y + (GRID_H << TILE_SHIFT));

  food_state_t      state_q, state_d;
  tile_idx_t        row_q, row_d;
  logic             eat_pulse_q, eat_pulse_d;
  logic [3:0]       rom_addr_q, rom_addr_d;
  logic [2:0]       col_q, col_d;
  logic             hit_q, hit_d;
  logic             food_on_q, food_on_d;
  logic             fill_en, load_en, eat;
  logic             pac_bit, pix_bit;
  logic [CNT_W-1:0] remaining;
  logic [9:0]       rx, ry, rx_tile, ry_tile;
  logic             in_grid;
  logic             pix_unused;

  // Range test is done on the raw coordinates so that pixels left of/above
  // the origin never wrap into the grid.
  assign rx      = bus.DrawX - 10'(ORIGIN_X);
  assign ry      = bus.DrawY - 10'(ORIGIN_Y);
  assign rx_tile = rx >> TILE_SHIFT;
  assign ry_tile = ry >> TILE_SHIFT;
  assign in_grid = ({22'd0, bus.DrawX} >= X_LO) && ({22'd0, bus.DrawX} < X_HI) &&
                   ({22'd0, bus.DrawY} >= Y_LO) && ({22'd0, bus.DrawY} < Y_HI);
  assign pix_unused = ^{rx[0], rx_tile[9:5], ry_tile[9:5]};

  food_bitmap #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .CNT_W  (CNT_W)
  ) u_bitmap (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .fill_en   (fill_en),
    .fill_row  (row_q),
    .load_en   (load_en),
    .clr_en    (eat),
    .pac_x     (bus.pac_tile_x),
    .pac_y     (bus.pac_tile_y),
    .pac_bit   (pac_bit),
    .pix_x     (rx_tile[4:0]),
    .pix_y     (ry_tile[4:0]),
    .pix_bit   (pix_bit),
    .remaining (remaining)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    fill_en = 1'b0;
    load_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.level_start) begin
          state_d = INIT;
          row_d   = '0;
        end
      end
      INIT: begin
        fill_en = 1'b1;
        if (bus.level_start) begin
          row_d = '0;
        end else if (row_q == LAST_ROW) begin
          load_en = 1'b1;
          state_d = PLAY;
        end else begin
          row_d = row_q + tile_idx_t'(1);
        end
      end
      PLAY: begin
        if (bus.level_start) begin
          state_d = INIT;
          row_d   = '0;
        end else if (remaining == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.level_start) begin
          state_d = INIT;
          row_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pac_bit is already forced low for out-of-range tiles.
  assign eat         = (state_q == PLAY) && bus.pac_valid && pac_bit;
  assign eat_pulse_d = eat;

  always_comb begin
    rom_addr_d = ry[3:0];
    col_d      = rx[3:1];
    hit_d      = in_grid & pix_bit;
    food_on_d  = hit_q & bus.food_rom_data[3'd7 - col_q];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      eat_pulse_q <= 1'b0;
      rom_addr_q  <= '0;
      col_q       <= '0;
      hit_q       <= 1'b0;
      food_on_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      eat_pulse_q <= eat_pulse_d;
      rom_addr_q  <= rom_addr_d;
      col_q       <= col_d;
      hit_q       <= hit_d;
      food_on_q   <= food_on_d;
    end
  end

  assign bus.food_rom_addr = rom_addr_q;
  assign bus.food_on       = food_on_q;
  assign bus.eat_pulse     = eat_pulse_q;
  assign bus.remaining     = remaining;
  assign bus.busy          = (state_q == INIT);
  assign bus.level_clear   = (state_q == DONE);

`ifdef FOOD_SCORE_EN
  localparam logic [CNT_W+3:0] SCORE_MAX = '1;
  localparam logic [CNT_W+3:0] SCORE_PTS = (CNT_W+4)'(PELLET_POINTS);

  logic [CNT_W+3:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (eat_pulse_q) score_d = (score_q > SCORE_MAX - SCORE_PTS) ? SCORE_MAX : score_q + SCORE_PTS;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) score_q <= '0;
    else          score_q <= score_d;
  end

  assign bus.score = score_q;
`endif

endmodule
